// File: rtl/write_back_if.sv
// Write-back stage bus: instruction fields from MEM, memory read return,
// upstream stall and register-file write port.
interface write_back_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_reg_wr_en;
    logic [1:0]        in_wb_sel;
    logic [1:0]        in_ld_size;
    logic              in_ld_unsigned;
    logic [OFF_W-1:0]  in_byte_off;
    logic [DATA_W-1:0] in_alu_result;
    logic [DATA_W-1:0] in_link_addr;
    logic [ADDR_W-1:0] in_reg_wr_addr;
    logic              flush;
    logic              mem_rd_valid;
    logic [DATA_W-1:0] mem_rd_data;
    logic              stall_out;
    logic              wb_reg_wr_en;
    logic [ADDR_W-1:0] wb_reg_wr_addr;
    logic [DATA_W-1:0] wb_reg_wr_data;

    modport master (
        output in_valid, in_reg_wr_en, in_wb_sel, in_ld_size, in_ld_unsigned,
               in_byte_off, in_alu_result, in_link_addr, in_reg_wr_addr,
               flush, mem_rd_valid, mem_rd_data,
        input  stall_out, wb_reg_wr_en, wb_reg_wr_addr, wb_reg_wr_data
    );

    modport slave (
        input  in_valid, in_reg_wr_en, in_wb_sel, in_ld_size, in_ld_unsigned,
               in_byte_off, in_alu_result, in_link_addr, in_reg_wr_addr,
               flush, mem_rd_valid, mem_rd_data,
        output stall_out, wb_reg_wr_en, wb_reg_wr_addr, wb_reg_wr_data
    );
endinterface

// File: rtl/write_back_pipe.sv
// Write-back stage: selects ALU/LINK results directly, or waits for a load
// return, aligns and extends it, then issues one register-file write.
//
// state | meaning
// IDLE  | ready to capture an instruction; mem_rd_valid ignored
// WAIT  | load captured, holding upstream until mem_rd_valid
module write_back_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    write_back_if.slave bus
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t            state;
    state_t            state_nx;
    logic              capture;
    logic              is_load;
    logic              load_done;
    logic              in_wen;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic [OFF_W-1:0]  cap_off;
    logic              cap_wen;
    logic [ADDR_W-1:0] cap_addr;
    logic [OFF_W-1:0]  off_h;
    logic [OFF_W-1:0]  off_w;
    logic [DATA_W-1:0] ld_shift;
    logic [DATA_W-1:0] ld_mask;
    logic              ld_sign;
    logic [DATA_W-1:0] ld_data;

    assign capture   = (state == IDLE) && bus.in_valid && !bus.flush;
    assign is_load   = (bus.in_wb_sel == 2'b01);
    assign load_done = (state == WAIT) && bus.mem_rd_valid && !bus.flush;
    // Writes to register 0 are suppressed but the instruction still sequences.
    assign in_wen    = bus.in_reg_wr_en && (bus.in_reg_wr_addr != '0);
    // Misaligned low offset bits are simply dropped for half/word loads.
    assign off_h     = cap_off & ~OFF_W'(1);
    assign off_w     = cap_off & ~OFF_W'(3);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (capture && is_load) state_nx = WAIT;
            WAIT:    if (bus.flush || bus.mem_rd_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.stall_out = (state == WAIT);
    end

    // Load alignment and zero/sign extension from the captured load shape
    always_comb begin
        ld_shift = bus.mem_rd_data;
        ld_mask  = '1;
        ld_sign  = bus.mem_rd_data[DATA_W-1];
        case (cap_size)
            2'b00: begin
                ld_shift = bus.mem_rd_data >> {cap_off, 3'b000};
                ld_mask  = DATA_W'(8'hFF);
                ld_sign  = ld_shift[7];
            end
            2'b01: begin
                ld_shift = bus.mem_rd_data >> {off_h, 3'b000};
                ld_mask  = DATA_W'(16'hFFFF);
                ld_sign  = ld_shift[15];
            end
            2'b10: begin
                ld_shift = bus.mem_rd_data >> {off_w, 3'b000};
                ld_mask  = DATA_W'(32'hFFFF_FFFF);
                ld_sign  = ld_shift[31];
            end
            default: ;
        endcase
        ld_data = (ld_shift & ld_mask) | ((!cap_uns && ld_sign) ? ~ld_mask : '0);
    end

    // Capture registers and write port; address/data only move on a real write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_size           <= '0;
            cap_uns            <= 1'b0;
            cap_off            <= '0;
            cap_wen            <= 1'b0;
            cap_addr           <= '0;
            bus.wb_reg_wr_en   <= 1'b0;
            bus.wb_reg_wr_addr <= '0;
            bus.wb_reg_wr_data <= '0;
        end else begin
            bus.wb_reg_wr_en <= 1'b0;
            if (capture) begin
                cap_size <= bus.in_ld_size;
                cap_uns  <= bus.in_ld_unsigned;
                cap_off  <= bus.in_byte_off;
                cap_wen  <= in_wen;
                cap_addr <= bus.in_reg_wr_addr;
                if (!is_load && in_wen) begin
                    bus.wb_reg_wr_en   <= 1'b1;
                    bus.wb_reg_wr_addr <= bus.in_reg_wr_addr;
                    bus.wb_reg_wr_data <= (bus.in_wb_sel == 2'b10) ?
                                          bus.in_link_addr : bus.in_alu_result;
                end
            end else if (load_done && cap_wen) begin
                bus.wb_reg_wr_en   <= 1'b1;
                bus.wb_reg_wr_addr <= cap_addr;
                bus.wb_reg_wr_data <= ld_data;
            end
        end
    end
endmodule

// File: tb/tb_write_back_pipe.sv
// Bench for write_back_pipe: directed scenarios plus randomized traffic
// against a behavioural model of the write-back rules.
module tb_write_back_pipe;
    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int OW  = $clog2(DW / 8);

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    write_back_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    write_back_pipe #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.in_valid       = 1'b0;
        bus.in_reg_wr_en   = 1'b0;
        bus.in_wb_sel      = 2'b00;
        bus.in_ld_size     = 2'b00;
        bus.in_ld_unsigned = 1'b0;
        bus.in_byte_off    = '0;
        bus.in_alu_result  = '0;
        bus.in_link_addr   = '0;
        bus.in_reg_wr_addr = '0;
        bus.flush          = 1'b0;
        bus.mem_rd_valid   = 1'b0;
        bus.mem_rd_data    = '0;
    endtask

    task automatic drive_op(input logic [1:0] sel, input logic [1:0] size,
                            input logic uns, input logic [OW-1:0] off,
                            input logic [DW-1:0] alu, input logic [DW-1:0] link,
                            input logic [AW-1:0] addr, input logic wen);
        bus.in_valid       = 1'b1;
        bus.in_reg_wr_en   = wen;
        bus.in_wb_sel      = sel;
        bus.in_ld_size     = size;
        bus.in_ld_unsigned = uns;
        bus.in_byte_off    = off;
        bus.in_alu_result  = alu;
        bus.in_link_addr   = link;
        bus.in_reg_wr_addr = addr;
    endtask

    // Field extraction by bit position: start/width from the load shape.
    function automatic logic [DW-1:0] model_load(input logic [DW-1:0] mem,
            input logic [1:0] size, input int off, input logic uns);
        int start;
        int width;
        logic [DW-1:0] r;
        case (size)
            2'd0:    begin width = 8;  start = off * 8; end
            2'd1:    begin width = 16; start = (off / 2) * 16; end
            2'd2:    begin width = 32; start = (DW == 64) ? (off / 4) * 32 : 0; end
            default: begin width = DW; start = 0; end
        endcase
        for (int i = 0; i < DW; i++) begin
            if (i < width) r[i] = mem[start + i];
            else           r[i] = uns ? 1'b0 : mem[start + width - 1];
        end
        return r;
    endfunction

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        drive_op(2'b00, 2'b00, 1'b0, '0, 32'hDEAD_BEEF, '0, 5'd7, 1'b1);
        bus.mem_rd_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0) begin failures++;
            $display("FAIL reset_en got=%b exp=0", bus.wb_reg_wr_en); end
        checks++;
        if (bus.wb_reg_wr_addr !== '0) begin failures++;
            $display("FAIL reset_addr got=%0d exp=0", bus.wb_reg_wr_addr); end
        checks++;
        if (bus.wb_reg_wr_data !== '0) begin failures++;
            $display("FAIL reset_data got=%h exp=0", bus.wb_reg_wr_data); end
        checks++;
        if (bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL reset_stall got=%b exp=0", bus.stall_out); end
        clear_inputs();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_op();
        drive_op(2'b00, 2'b00, 1'b0, '0, 32'h0000_1234, 32'h5555_5555, 5'd8, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b1) begin failures++;
            $display("FAIL alu_en got=%b exp=1", bus.wb_reg_wr_en); end
        checks++;
        if (bus.wb_reg_wr_addr !== 5'd8) begin failures++;
            $display("FAIL alu_addr got=%0d exp=8", bus.wb_reg_wr_addr); end
        checks++;
        if (bus.wb_reg_wr_data !== 32'h0000_1234) begin failures++;
            $display("FAIL alu_data got=%h exp=00001234", bus.wb_reg_wr_data); end
        checks++;
        if (bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL alu_stall got=%b exp=0", bus.stall_out); end
        tick();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0) begin failures++;
            $display("FAIL alu_single_pulse got=%b exp=0", bus.wb_reg_wr_en); end
    endtask

    task automatic test_signed_byte();
        drive_op(2'b01, 2'b00, 1'b0, 2'd2, '0, '0, 5'd4, 1'b1);
        tick();
        // Upstream keeps presenting an ALU op; it must be ignored in WAIT.
        drive_op(2'b00, 2'b00, 1'b0, '0, 32'h1111_1111, '0, 5'd9, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin
                bus.mem_rd_valid = 1'b1;
                bus.mem_rd_data  = 32'h0080_0000;
            end
            checks++;
            if (bus.stall_out !== 1'b1) begin failures++;
                $display("FAIL sbyte_stall_c%0d got=%b exp=1", c, bus.stall_out); end
            checks++;
            if (bus.wb_reg_wr_en !== 1'b0) begin failures++;
                $display("FAIL sbyte_no_strobe_c%0d got=%b exp=0", c, bus.wb_reg_wr_en); end
            if (c < 3) tick();
        end
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b1 || bus.wb_reg_wr_addr !== 5'd4) begin failures++;
            $display("FAIL sbyte_write got en=%b addr=%0d exp en=1 addr=4",
                     bus.wb_reg_wr_en, bus.wb_reg_wr_addr); end
        checks++;
        if (bus.wb_reg_wr_data !== 32'hFFFF_FF80) begin failures++;
            $display("FAIL sbyte_data got=%h exp=ffffff80", bus.wb_reg_wr_data); end
        checks++;
        if (bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL sbyte_stall_end got=%b exp=0", bus.stall_out); end
    endtask

    task automatic test_half_loads();
        logic [DW-1:0] exp_d [2];
        exp_d[0] = 32'h0000_8001;
        exp_d[1] = 32'hFFFF_8001;
        for (int k = 0; k < 2; k++) begin
            drive_op(2'b01, 2'b01, (k == 0), 2'd2, '0, '0, 5'd12, 1'b1);
            tick();
            clear_inputs();
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 32'h8001_0000;
            tick();
            clear_inputs();
            checks++;
            if (bus.wb_reg_wr_en !== 1'b1 || bus.wb_reg_wr_data !== exp_d[k]) begin failures++;
                $display("FAIL half_load_%0d got en=%b data=%h exp en=1 data=%h",
                         k, bus.wb_reg_wr_en, bus.wb_reg_wr_data, exp_d[k]); end
        end
    endtask

    task automatic test_zero_reg();
        drive_op(2'b10, 2'b00, 1'b0, '0, 32'h7777_7777, 32'h0040_0008, 5'd0, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0 || bus.wb_reg_wr_addr !== 5'd12 ||
            bus.wb_reg_wr_data !== 32'hFFFF_8001) begin failures++;
            $display("FAIL zero_reg_hold got en=%b addr=%0d data=%h exp en=0 addr=12 data=ffff8001",
                     bus.wb_reg_wr_en, bus.wb_reg_wr_addr, bus.wb_reg_wr_data); end
        drive_op(2'b10, 2'b00, 1'b0, '0, 32'h7777_7777, 32'h0040_0008, 5'd31, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b1 || bus.wb_reg_wr_addr !== 5'd31 ||
            bus.wb_reg_wr_data !== 32'h0040_0008) begin failures++;
            $display("FAIL link_r31 got en=%b addr=%0d data=%h exp en=1 addr=31 data=00400008",
                     bus.wb_reg_wr_en, bus.wb_reg_wr_addr, bus.wb_reg_wr_data); end
    endtask

    task automatic test_flush_wait();
        drive_op(2'b01, 2'b11, 1'b0, '0, '0, '0, 5'd6, 1'b1);
        tick();
        clear_inputs();
        bus.flush        = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'hABCD_0123;
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0 || bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL flush_wait got en=%b stall=%b exp en=0 stall=0",
                     bus.wb_reg_wr_en, bus.stall_out); end
        drive_op(2'b11, 2'b00, 1'b0, '0, 32'h0BAD_F00D, '0, 5'd5, 1'b1);
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b1 || bus.wb_reg_wr_addr !== 5'd5 ||
            bus.wb_reg_wr_data !== 32'h0BAD_F00D) begin failures++;
            $display("FAIL after_flush got en=%b addr=%0d data=%h exp en=1 addr=5 data=0badf00d",
                     bus.wb_reg_wr_en, bus.wb_reg_wr_addr, bus.wb_reg_wr_data); end
    endtask

    task automatic test_reset_in_wait();
        drive_op(2'b01, 2'b10, 1'b1, '0, '0, '0, 5'd3, 1'b1);
        tick();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0 || bus.wb_reg_wr_addr !== '0 ||
            bus.wb_reg_wr_data !== '0 || bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL reset_wait got en=%b addr=%0d data=%h stall=%b exp all 0",
                     bus.wb_reg_wr_en, bus.wb_reg_wr_addr, bus.wb_reg_wr_data, bus.stall_out); end
        rst_n = 1'b1;
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = 32'h1234_5678;
        tick();
        clear_inputs();
        checks++;
        if (bus.wb_reg_wr_en !== 1'b0 || bus.stall_out !== 1'b0) begin failures++;
            $display("FAIL late_mem_valid got en=%b stall=%b exp en=0 stall=0",
                     bus.wb_reg_wr_en, bus.stall_out); end
    endtask

    task automatic test_random();
        logic          m_pend;
        logic [1:0]    m_size;
        logic          m_uns;
        int            m_off;
        logic          m_wen;
        logic [AW-1:0] m_addr;
        logic          e_en;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;

        rst_n = 1'b0;
        clear_inputs();
        tick();
        rst_n  = 1'b1;
        m_pend = 1'b0; m_size = '0; m_uns = 1'b0; m_off = 0; m_wen = 1'b0; m_addr = '0;
        e_addr = '0; e_data = '0;

        for (int n = 0; n < 400; n++) begin
            rst_n              = ($urandom_range(0, 49) != 0);
            bus.in_valid       = ($urandom_range(0, 3) != 0);
            bus.in_reg_wr_en   = ($urandom_range(0, 5) != 0);
            bus.in_wb_sel      = 2'($urandom_range(0, 3));
            bus.in_ld_size     = 2'($urandom_range(0, 3));
            bus.in_ld_unsigned = 1'($urandom_range(0, 1));
            bus.in_byte_off    = OW'($urandom_range(0, (1 << OW) - 1));
            bus.in_alu_result  = DW'($urandom);
            bus.in_link_addr   = DW'($urandom);
            bus.in_reg_wr_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
            bus.flush          = ($urandom_range(0, 9) == 0);
            bus.mem_rd_valid   = ($urandom_range(0, 2) == 0);
            bus.mem_rd_data    = DW'($urandom);

            e_en = 1'b0;
            if (!rst_n) begin
                m_pend = 1'b0; e_addr = '0; e_data = '0;
            end else if (bus.flush) begin
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (bus.mem_rd_valid) begin
                    m_pend = 1'b0;
                    if (m_wen) begin
                        e_en = 1'b1; e_addr = m_addr;
                        e_data = model_load(bus.mem_rd_data, m_size, m_off, m_uns);
                    end
                end
            end else if (bus.in_valid) begin
                if (bus.in_wb_sel == 2'b01) begin
                    m_pend = 1'b1;
                    m_size = bus.in_ld_size;
                    m_uns  = bus.in_ld_unsigned;
                    m_off  = int'(bus.in_byte_off);
                    m_wen  = bus.in_reg_wr_en && (bus.in_reg_wr_addr != 0);
                    m_addr = bus.in_reg_wr_addr;
                end else if (bus.in_reg_wr_en && bus.in_reg_wr_addr != 0) begin
                    e_en   = 1'b1;
                    e_addr = bus.in_reg_wr_addr;
                    e_data = (bus.in_wb_sel == 2'b10) ? bus.in_link_addr : bus.in_alu_result;
                end
            end

            tick();
            checks++;
            if (bus.wb_reg_wr_en !== e_en) begin failures++;
                $display("FAIL rand_en[%0d] got=%b exp=%b", n, bus.wb_reg_wr_en, e_en); end
            checks++;
            if (bus.wb_reg_wr_addr !== e_addr) begin failures++;
                $display("FAIL rand_addr[%0d] got=%0d exp=%0d", n, bus.wb_reg_wr_addr, e_addr); end
            checks++;
            if (bus.wb_reg_wr_data !== e_data) begin failures++;
                $display("FAIL rand_data[%0d] got=%h exp=%h", n, bus.wb_reg_wr_data, e_data); end
            checks++;
            if (bus.stall_out !== m_pend) begin failures++;
                $display("FAIL rand_stall[%0d] got=%b exp=%b", n, bus.stall_out, m_pend); end
        end
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_alu_op();
        test_signed_byte();
        test_half_loads();
        test_zero_reg();
        test_flush_wait();
        test_reset_in_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write_back_pipe.md
WRITE_BACK_PIPE -- requirements
Module: write_back_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-file address width.
REQ-003 SHALL derive local OFF_W = clog2(DATA_W/8), meaning byte-offset width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 in_valid  input  1  instruction present from MEM stage.
REQ-007 in_reg_wr_en  input  1  instruction writes register file.
REQ-008 in_wb_sel  input  2  source select: 00 ALU, 01 MEM, 10 LINK, 11 ALU.
REQ-009 in_ld_size  input  2  load size: 00 byte, 01 half, 10 word (32b), 11 full DATA_W.
REQ-010 in_ld_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
REQ-011 in_byte_off  input  OFF_W  load byte offset within mem_rd_data.
REQ-012 in_alu_result  input  DATA_W  ALU result.
REQ-013 in_link_addr  input  DATA_W  return address for link instructions.
REQ-014 in_reg_wr_addr  input  ADDR_W  destination register.
REQ-015 flush  input  1  discard pending instruction.
REQ-016 mem_rd_valid  input  1  mem_rd_data valid this cycle.
REQ-017 mem_rd_data  input  DATA_W  memory read data.
REQ-018 stall_out  output  1  upstream hold request.
REQ-019 wb_reg_wr_en  output  1  register-file write strobe.
REQ-020 wb_reg_wr_addr  output  ADDR_W  write address.
REQ-021 wb_reg_wr_data  output  DATA_W  write data.

Function
REQ-022 SHALL implement FSM states IDLE and WAIT; stall_out SHALL be 1 exactly when state is WAIT (combinational from state).
REQ-023 Capture: in IDLE with in_valid=1 and flush=0, block SHALL latch all in_* fields at the edge.
REQ-024 Captured non-load (in_wb_sel != 01): wb_reg_wr_en SHALL pulse high for exactly the next cycle with selected data; latency 1 cycle; state stays IDLE, back-to-back captures each cycle allowed.
REQ-025 Captured load (in_wb_sel = 01): state SHALL go to WAIT; no write strobe while in WAIT.
REQ-026 In WAIT, in_valid SHALL be ignored; mem_rd_valid=1 SHALL cause aligned data to be registered, wb_reg_wr_en to pulse for the next cycle, state to return to IDLE.
REQ-027 mem_rd_valid in IDLE SHALL be ignored.
REQ-028 Alignment: byte = mem_rd_data[8*off +: 8]; half = [16*off[OFF_W-1:1] +: 16]; word = [32*off[OFF_W-1:2] +: 32] (DATA_W=64) or full word (DATA_W=32); size 11 = full DATA_W, offset ignored; misaligned low offset bits ignored.
REQ-029 Extension: result zero-extended when in_ld_unsigned=1, else sign-extended from field MSB, to DATA_W.
REQ-030 wb_reg_wr_en SHALL be forced 0 when captured in_reg_wr_en=0 or in_reg_wr_addr=0; FSM sequencing unchanged.
REQ-031 flush=1 SHALL take priority over capture and mem_rd_valid in same cycle: pending instruction dropped, no write strobe next cycle, state IDLE.
REQ-032 wb_reg_wr_addr and wb_reg_wr_data SHALL be registered and hold last written values when wb_reg_wr_en=0.
REQ-033 At most one write strobe per captured instruction.

Reset
REQ-034 rst_n=0 at an edge SHALL set state IDLE, wb_reg_wr_en 0, wb_reg_wr_addr 0, wb_reg_wr_data 0, stall_out 0, overriding flush, capture and mem_rd_valid.
REQ-035 Reset during WAIT SHALL abandon the load with no write strobe.

Verification
REQ-036 ALU op: in_valid=1, sel=00, alu=0x0000_1234, addr=8 -> next cycle wr_en=1, addr=8, data=0x0000_1234, stall_out=0.
REQ-037 Signed byte load: sel=01, size=00, off=2, signed; mem_rd_valid after 3 cycles, data=0x0080_0000 -> stall_out=1 for 3 cycles, then wr_en=1, data=0xFFFF_FF80.
REQ-038 Unsigned half load: off=2, data=0x8001_0000 -> data=0x0000_8001; same signed -> 0xFFFF_8001.
REQ-039 $zero: sel=10, link=0x0040_0008, addr=0 -> wr_en stays 0; addr=31 -> data=0x0040_0008.
REQ-040 flush in WAIT with simultaneous mem_rd_valid -> no strobe, stall_out=0 next cycle; next ALU op writes normally.
REQ-041 rst_n=0 in WAIT -> all outputs 0 next cycle; late mem_rd_valid afterwards ignored.
